// File: rtl/instr_encoder_loader_pkg.sv
// Shared RV32I encoding constants: opcodes (common with the decoder), request class codes,
// rejection codes, the NOP word and the loader FSM state type.
package instr_encoder_loader_pkg;

  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;
  localparam logic [6:0] OP_L = 7'b0000011;
  localparam logic [6:0] OP_S = 7'b0100011;
  localparam logic [6:0] OP_B = 7'b1100011;

  localparam logic [2:0] CLS_R = 3'd0;
  localparam logic [2:0] CLS_I = 3'd1;
  localparam logic [2:0] CLS_L = 3'd2;
  localparam logic [2:0] CLS_S = 3'd3;
  localparam logic [2:0] CLS_B = 3'd4;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_CLASS = 2'd1;
  localparam logic [1:0] ERR_B_ODD = 2'd2;
  localparam logic [1:0] ERR_L_F3  = 2'd3;

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ENCODE = 2'd1,
    S_WRITE  = 2'd2
  } enc_state_e;

endpackage

// File: rtl/instr_encoder_loader_format.sv
// Purely combinational field-to-word packer for RV32I R/I/L/S/B classes.
// Unknown classes produce the canonical NOP (addi x0, x0, 0).
module instr_encoder_loader_format
  import instr_encoder_loader_pkg::*;
(
  input  logic [2:0]  cls,
  input  logic [2:0]  funct3,
  input  logic        funct7b5,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [12:0] imm,
  output logic [31:0] word
);

  always_comb begin
    word = NOP_WORD;
    case (cls)
      CLS_R: word = {1'b0, funct7b5, 5'b0, rs2, rs1, funct3, rd, OP_R};
      CLS_I: begin
        // Shift-immediates carry funct7 in imm[11:5]; only shamt comes from imm.
        if (funct3 == 3'b001 || funct3 == 3'b101)
          word = {1'b0, funct7b5, 5'b0, imm[4:0], rs1, funct3, rd, OP_I};
        else
          word = {imm[11:0], rs1, funct3, rd, OP_I};
      end
      CLS_L: word = {imm[11:0], rs1, funct3, rd, OP_L};
      CLS_S: word = {imm[11:5], rs2, rs1, funct3, imm[4:0], OP_S};
      CLS_B: word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OP_B};
      default: word = NOP_WORD;
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Program loader: encodes valid/ready requests into RV32I words and writes them to imem at an
// auto-incrementing address. Define ENCODER_CHECK_EN to reject malformed requests via errValid/errCode.
module instr_encoder_loader
  import instr_encoder_loader_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              reqValid,
  output logic              reqReady,
  input  logic [2:0]        reqClass,
  input  logic [2:0]        reqFunct3,
  input  logic              reqFunct7b5,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [12:0]       imm,
  output logic              imemWe,
  output logic [ADDR_W-1:0] imemAddr,
  output logic [31:0]       imemData,
  output logic [ADDR_W:0]   wordCount,
  output logic              full,
  output logic              errValid,
  output logic [1:0]        errCode,
  output logic [1:0]        state_dbg
);

  // Handshake: a request transfers on a rising edge where reqValid && reqReady; the requester
  // holds its fields stable while reqValid is high and reqReady is low.

  localparam int unsigned CAP = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] BASE = BASE_ADDR[ADDR_W-1:0];

  enc_state_e state, next;
  logic [2:0]        cls_q, f3_q;
  logic              f7_q;
  logic [4:0]        rd_q, rs1_q, rs2_q;
  logic [12:0]       imm_q;
  logic [31:0]       word;
  logic [ADDR_W-1:0] ptr;
  logic              clr_pend;
  logic              accept;
  logic [1:0]        chk_code;
  logic              chk_err;

  assign full      = (wordCount == CAP[ADDR_W:0]);
  assign reqReady  = (state == S_IDLE) && !full && !clear;
  assign accept    = reqValid && reqReady;
  assign imemWe    = (state == S_WRITE);
  assign state_dbg = state;
  assign chk_err   = (chk_code != ERR_NONE);

  instr_encoder_loader_format u_format (
    .cls      (cls_q),
    .funct3   (f3_q),
    .funct7b5 (f7_q),
    .rd       (rd_q),
    .rs1      (rs1_q),
    .rs2      (rs2_q),
    .imm      (imm_q),
    .word     (word)
  );

`ifdef ENCODER_CHECK_EN
  always_comb begin
    chk_code = ERR_NONE;
    if (cls_q > CLS_B)
      chk_code = ERR_CLASS;
    else if (cls_q == CLS_B && imm_q[0])
      chk_code = ERR_B_ODD;
    else if (cls_q == CLS_L && (f3_q == 3'd3 || f3_q == 3'd6 || f3_q == 3'd7))
      chk_code = ERR_L_F3;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      errValid <= 1'b0;
      errCode  <= ERR_NONE;
    end else begin
      errValid <= (state == S_ENCODE) && chk_err;
      errCode  <= (state == S_ENCODE) ? chk_code : ERR_NONE;
    end
  end
`else
  assign chk_code = ERR_NONE;
  assign errValid = 1'b0;
  assign errCode  = ERR_NONE;
`endif

  always_comb begin
    next = state;
    case (state)
      S_IDLE:   if (accept) next = S_ENCODE;
      S_ENCODE: next = chk_err ? S_IDLE : S_WRITE;
      S_WRITE:  next = S_IDLE;
      default:  next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cls_q <= '0;
      f3_q  <= '0;
      f7_q  <= 1'b0;
      rd_q  <= '0;
      rs1_q <= '0;
      rs2_q <= '0;
      imm_q <= '0;
    end else if (accept) begin
      cls_q <= reqClass;
      f3_q  <= reqFunct3;
      f7_q  <= reqFunct7b5;
      rd_q  <= rd;
      rs1_q <= rs1;
      rs2_q <= rs2;
      imm_q <= imm;
    end
  end

  // Address/data are captured only for words that will be written, so they hold between writes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      imemAddr <= BASE;
      imemData <= '0;
    end else if (state == S_ENCODE && next == S_WRITE) begin
      imemAddr <= ptr;
      imemData <= word;
    end
  end

  // A clear seen mid-operation is remembered so the in-flight word still lands first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr       <= BASE;
      wordCount <= '0;
      clr_pend  <= 1'b0;
    end else begin
      clr_pend <= (state == S_ENCODE) && (next == S_WRITE) && clear;
      if (state == S_IDLE) begin
        if (clear) begin
          ptr       <= BASE;
          wordCount <= '0;
        end
      end else if (next == S_IDLE) begin
        if (clear || clr_pend) begin
          ptr       <= BASE;
          wordCount <= '0;
        end else if (state == S_WRITE) begin
          ptr       <= ptr + 1'b1;
          wordCount <= wordCount + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Bench for instr_encoder_loader (ADDR_W=2): vector table plus hand sequences for full/clear/reset.
module tb_instr_encoder_loader;

  localparam int ADDR_W = 2;
`ifdef ENCODER_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  typedef struct {
    logic [2:0]  cls;
    logic [2:0]  f3;
    logic        f7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [12:0] imm;
    logic [31:0] exp_data;
    logic [1:0]  exp_err;
  } vec_t;

  logic              clk, reset, clear, reqValid, reqReady;
  logic [2:0]        reqClass, reqFunct3;
  logic              reqFunct7b5;
  logic [4:0]        rd, rs1, rs2;
  logic [12:0]       imm;
  logic              imemWe;
  logic [ADDR_W-1:0] imemAddr;
  logic [31:0]       imemData;
  logic [ADDR_W:0]   wordCount;
  logic              full, errValid;
  logic [1:0]        errCode, state_dbg;

  logic [ADDR_W+31:0] exp_q[$];
  logic [1:0]         err_q[$];
  int n_cmp  = 0;
  int n_fail = 0;
  int exp_count = 0;
  vec_t vecs[11];

  instr_encoder_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(0)) dut (
    .clk(clk), .reset(reset), .clear(clear), .reqValid(reqValid), .reqReady(reqReady),
    .reqClass(reqClass), .reqFunct3(reqFunct3), .reqFunct7b5(reqFunct7b5),
    .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .imemWe(imemWe), .imemAddr(imemAddr), .imemData(imemData),
    .wordCount(wordCount), .full(full), .errValid(errValid), .errCode(errCode),
    .state_dbg(state_dbg)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  // scoreboard
  always @(negedge clk) begin
    if (imemWe === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL write_unexpected: got addr=%0d data=%08h, required no write", imemAddr, imemData);
      end else begin
        logic [ADDR_W+31:0] e;
        e = exp_q.pop_front();
        if ({imemAddr, imemData} !== e) begin
          n_fail++;
          $display("FAIL write: got addr=%0d data=%08h, required addr=%0d data=%08h",
                   imemAddr, imemData, e[ADDR_W+31:32], e[31:0]);
        end
      end
    end
    if (errValid === 1'b1) begin
      n_cmp++;
      if (err_q.size() == 0) begin
        n_fail++;
        $display("FAIL err_unexpected: got code=%0d, required no error", errCode);
      end else begin
        logic [1:0] ec;
        ec = err_q.pop_front();
        if (errCode !== ec) begin
          n_fail++;
          $display("FAIL err_code: got %0d, required %0d", errCode, ec);
        end
      end
    end
  end

  // drivers (called and returning at a falling edge)
  task automatic push_write(input logic [31:0] data);
    logic [ADDR_W-1:0] a;
    a = exp_count[ADDR_W-1:0];
    exp_q.push_back({a, data});
    exp_count++;
  endtask

  task automatic send(input vec_t v);
    int n;
    reqClass = v.cls; reqFunct3 = v.f3; reqFunct7b5 = v.f7;
    rd = v.rd; rs1 = v.rs1; rs2 = v.rs2; imm = v.imm;
    reqValid = 1'b1;
    #1;
    n = 0;
    while (reqReady !== 1'b1 && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    if (reqReady !== 1'b1) begin
      chk("send_ready_timeout", 64'(reqReady), 64'd1);
      @(negedge clk);
    end else begin
      @(posedge clk);
      @(negedge clk);
    end
    reqValid = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    exp_count = 0;
  endtask

  task automatic wait_neg(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    vecs[0]  = '{3'd0, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 13'h0000, 32'h002081B3, 2'd0};
    vecs[1]  = '{3'd3, 3'd2, 1'b0, 5'd0, 5'd2, 5'd5, 13'h0008, 32'h00512423, 2'd0};
    vecs[2]  = '{3'd4, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 13'h1FFC, 32'hFE208EE3, 2'd0};
    vecs[3]  = '{3'd1, 3'd5, 1'b1, 5'd1, 5'd1, 5'd0, 13'h0003, 32'h4030D093, 2'd0};
    vecs[4]  = '{3'd1, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 13'h0FFF, 32'hFFF00293, 2'd0};
    vecs[5]  = '{3'd2, 3'd2, 1'b0, 5'd6, 5'd2, 5'd0, 13'h0004, 32'h00412303, 2'd0};
    vecs[6]  = '{3'd0, 3'd0, 1'b1, 5'd1, 5'd2, 5'd3, 13'h0000, 32'h403100B3, 2'd0};
    vecs[7]  = '{3'd1, 3'd1, 1'b0, 5'd7, 5'd7, 5'd0, 13'h0FE5, 32'h00539393, 2'd0};
    vecs[8]  = '{3'd5, 3'd0, 1'b0, 5'd1, 5'd1, 5'd1, 13'h0000, 32'h00000013, 2'd1};
    vecs[9]  = '{3'd2, 3'd3, 1'b0, 5'd1, 5'd1, 5'd0, 13'h0000, 32'h0000B083, 2'd3};
    vecs[10] = '{3'd4, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 13'h0005, 32'h00208263, 2'd2};

    reset = 1'b0; clear = 1'b0; reqValid = 1'b0;
    reqClass = '0; reqFunct3 = '0; reqFunct7b5 = 1'b0;
    rd = '0; rs1 = '0; rs2 = '0; imm = '0;
    #1 reset = 1'b1;
    wait_neg(2);
    reset = 1'b0;
    @(negedge clk);

    chk("reset_reqReady", 64'(reqReady), 64'd1);
    chk("reset_imemWe", 64'(imemWe), 64'd0);
    chk("reset_imemAddr", 64'(imemAddr), 64'd0);
    chk("reset_imemData", 64'(imemData), 64'd0);
    chk("reset_wordCount", 64'(wordCount), 64'd0);
    chk("reset_full", 64'(full), 64'd0);
    chk("reset_errValid", 64'(errValid), 64'd0);
    chk("reset_errCode", 64'(errCode), 64'd0);

    // table: wordCount follows the expected number of writes
    for (int i = 0; i < 11; i++) begin
      if (exp_count == (1 << ADDR_W)) pulse_clear();
      if (CHK && vecs[i].exp_err != 2'd0) err_q.push_back(vecs[i].exp_err);
      else push_write(vecs[i].exp_data);
      send(vecs[i]);
      wait_neg(2);
      chk($sformatf("vec%0d_wordCount", i), 64'(wordCount), 64'(exp_count));
    end

    // fill to capacity with back-to-back requests; 5th must wait until clear
    pulse_clear();
    chk("clear_wordCount", 64'(wordCount), 64'd0);
    for (int i = 0; i < 4; i++) begin
      push_write(vecs[i].exp_data);
      send(vecs[i]);
    end
    reqClass = vecs[4].cls; reqFunct3 = vecs[4].f3; reqFunct7b5 = vecs[4].f7;
    rd = vecs[4].rd; rs1 = vecs[4].rs1; rs2 = vecs[4].rs2; imm = vecs[4].imm;
    reqValid = 1'b1;
    wait_neg(6);
    chk("full_flag", 64'(full), 64'd1);
    chk("full_reqReady", 64'(reqReady), 64'd0);
    chk("full_wordCount", 64'(wordCount), 64'd4);
    pulse_clear();
    chk("clear_at_full_wordCount", 64'(wordCount), 64'd0);
    chk("clear_at_full_full", 64'(full), 64'd0);
    push_write(vecs[4].exp_data);
    send(vecs[4]);
    wait_neg(2);
    chk("after_clear_wordCount", 64'(wordCount), 64'd1);

    // clear while encoding: word still lands at addr 1, then count returns to 0
    push_write(vecs[5].exp_data);
    send(vecs[5]);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    @(negedge clk);
    exp_count = 0;
    chk("clear_mid_wordCount", 64'(wordCount), 64'd0);

    // reset while encoding: no write, outputs back to reset values
    push_write(vecs[6].exp_data);
    send(vecs[6]);
    wait_neg(2);
    send(vecs[7]);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_imemWe", 64'(imemWe), 64'd0);
    chk("rst_mid_imemAddr", 64'(imemAddr), 64'd0);
    chk("rst_mid_imemData", 64'(imemData), 64'd0);
    chk("rst_mid_wordCount", 64'(wordCount), 64'd0);
    chk("rst_mid_reqReady", 64'(reqReady), 64'd1);
    reset = 1'b0;
    exp_count = 0;
    wait_neg(4);

    chk("pending_writes", 64'(exp_q.size()), 64'd0);
    chk("pending_errors", 64'(err_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
